// File: rtl/enc_8_3_evt.sv
// enc_8_3_evt: captures active-low falling-edge events and drains them as a priority-encoded valid/ready index stream
module enc_8_3_evt #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] req_n,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ready,
    output logic       lost,
    output logic [2:0] lost_idx,
    output logic       busy
);
    logic [7:0] s, prev, pending, fall, ld_mask, lost_vec, pending_next;
    logic       load;

    function automatic logic [2:0] lowest(input logic [7:0] v);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) lowest = 3'(i);
    endfunction

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = req_n;
        end else begin : g_sync
            logic [7:0] chain [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= 8'hFF;
                end else begin
                    chain[0] <= req_n;
                    for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
                end
            end
            assign s = chain[SYNC_STAGES-1];
        end
    endgenerate

    // A bit being loaded this edge may be re-captured without counting as lost.
    always_comb begin
        fall         = enable ? 8'h00 : (prev & ~s);
        load         = (!valid || ready) && (pending != 8'h00);
        ld_mask      = load ? (8'd1 << lowest(pending)) : 8'h00;
        lost_vec     = fall & pending & ~ld_mask;
        pending_next = (pending & ~ld_mask) | (fall & (~pending | ld_mask));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= 8'hFF;
            pending  <= 8'h00;
            valid    <= 1'b0;
            code     <= 3'd0;
            lost     <= 1'b0;
            lost_idx <= 3'd0;
        end else begin
            prev     <= s;
            pending  <= pending_next;
            lost     <= |lost_vec;
            lost_idx <= lowest(lost_vec);
            if (load) begin
                valid <= 1'b1;
                code  <= lowest(pending);
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy = (pending != 8'h00) | valid;
endmodule

// File: tb/tb_enc_8_3_evt.sv
// tb_enc_8_3_evt: directed steps with an expected-code scoreboard popped on each handshake
module tb_enc_8_3_evt;
    logic       clk = 1'b0;
    logic       rst, enable, ready, ready_z;
    logic [7:0] req_n, req_z;
    logic [2:0] code, lost_idx, code_z, lost_idx_z;
    logic       valid, lost, busy, valid_z, lost_z, busy_z;
    int         checks = 0;
    int         errors = 0;
    int         lost_cnt = 0;
    logic [2:0] last_lost_idx = 3'd0;
    logic [2:0] q[$];

    always #5 clk = ~clk;

    enc_8_3_evt dut (
        .clk(clk), .rst(rst), .enable(enable), .req_n(req_n), .code(code), .valid(valid),
        .ready(ready), .lost(lost), .lost_idx(lost_idx), .busy(busy)
    );

    enc_8_3_evt #(.SYNC_STAGES(0)) dut_z (
        .clk(clk), .rst(rst), .enable(enable), .req_n(req_z), .code(code_z), .valid(valid_z),
        .ready(ready_z), .lost(lost_z), .lost_idx(lost_idx_z), .busy(busy_z)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra: observed code %0d expected no handshake", code);
            end
            if (q.size() != 0) chk("sb_code", {5'd0, code}, {5'd0, q.pop_front()});
        end
        if (!rst && lost) begin
            lost_cnt++;
            last_lost_idx = lost_idx;
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; ready = 1'b0; ready_z = 1'b1;
        req_n = 8'hFF; req_z = 8'hFF;
        tick(2);
        rst = 1'b0;
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_code", {5'd0, code}, 8'd0);
        chk("rst_lost", {7'd0, lost}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);

        // 1: single held-low line, latency 4 edges
        ready = 1'b1; req_n = 8'hF7; q.push_back(3'd3);
        tick(3);
        chk("t1_pre_valid", {7'd0, valid}, 8'd0);
        chk("t1_pre_busy", {7'd0, busy}, 8'd1);
        tick(1);
        chk("t1_valid", {7'd0, valid}, 8'd1);
        chk("t1_code", {5'd0, code}, 8'd3);
        tick(1);
        chk("t1_drop", {7'd0, valid}, 8'd0);
        tick(5);
        chk("t1_once", {7'd0, busy}, 8'd0);
        req_n = 8'hFF; tick(4);

        // 2: burst of four, drained in priority order
        ready = 1'b0; req_n = 8'b0101_1010;
        q.push_back(3'd0); q.push_back(3'd2); q.push_back(3'd5); q.push_back(3'd7);
        tick(9);
        chk("t2_hold_valid", {7'd0, valid}, 8'd1);
        chk("t2_hold_code", {5'd0, code}, 8'd0);
        ready = 1'b1; tick(4);
        chk("t2_done_valid", {7'd0, valid}, 8'd0);
        chk("t2_done_busy", {7'd0, busy}, 8'd0);
        req_n = 8'hFF; ready = 1'b0; tick(4);

        // 3: no pre-emption of the presented code
        req_n = 8'hBF; q.push_back(3'd6); tick(4);
        chk("t3_code6", {5'd0, code}, 8'd6);
        req_n = 8'hBD; q.push_back(3'd1); tick(5);
        chk("t3_hold6", {5'd0, code}, 8'd6);
        ready = 1'b1; tick(1);
        chk("t3_code1", {5'd0, code}, 8'd1);
        tick(1);
        chk("t3_done", {7'd0, valid}, 8'd0);
        req_n = 8'hFF; ready = 1'b0; tick(4);

        // 4: re-fall of a pending, unpresented line is lost
        req_n = 8'hDF; q.push_back(3'd5); tick(4);
        chk("t4_code5", {5'd0, code}, 8'd5);
        req_n = 8'hCF; q.push_back(3'd4); tick(3);
        req_n = 8'hDF; tick(3);
        req_n = 8'hCF; tick(3);
        ready = 1'b1; tick(3);
        chk("t4_lost_cnt", lost_cnt[7:0], 8'd1);
        chk("t4_lost_idx", {5'd0, last_lost_idx}, 8'd4);
        chk("t4_q_empty", q.size() == 0 ? 8'd1 : 8'd0, 8'd1);
        req_n = 8'hFF; ready = 1'b0; tick(4);

        // 5: disabled capture is not replayed later
        enable = 1'b1; req_n = 8'hFB; tick(4);
        chk("t5_dis_busy", {7'd0, busy}, 8'd0);
        enable = 1'b0; tick(4);
        chk("t5_late_busy", {7'd0, busy}, 8'd0);
        req_n = 8'hFF; tick(3);
        req_n = 8'hFB; q.push_back(3'd2); ready = 1'b1; tick(4);
        chk("t5_valid", {7'd0, valid}, 8'd1);
        chk("t5_code", {5'd0, code}, 8'd2);
        tick(1);
        req_n = 8'hFF; ready = 1'b0; tick(4);

        // 6: reset discards everything; zero-stage build latency
        req_n = 8'hF3; tick(4);
        chk("t6_pre_code", {5'd0, code}, 8'd2);
        chk("t6_pre_busy", {7'd0, busy}, 8'd1);
        rst = 1'b1; req_n = 8'hFF; tick(1);
        rst = 1'b0; q.delete();
        chk("t6_rst_valid", {7'd0, valid}, 8'd0);
        chk("t6_rst_busy", {7'd0, busy}, 8'd0);
        chk("t6_rst_code", {5'd0, code}, 8'd0);
        tick(4);
        chk("t6_quiet", {7'd0, busy}, 8'd0);
        req_z = 8'hFE; tick(1);
        chk("z_pre_valid", {7'd0, valid_z}, 8'd0);
        chk("z_pre_busy", {7'd0, busy_z}, 8'd1);
        tick(1);
        chk("z_valid", {7'd0, valid_z}, 8'd1);
        chk("z_code", {5'd0, code_z}, 8'd0);

        for (int i = 0; i < 50 && (q.size() != 0 || busy); i++) tick(1);
        chk("final_q_empty", q.size() == 0 ? 8'd1 : 8'd0, 8'd1);
        chk("final_busy", {7'd0, busy}, 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
